// File: rtl/branch_flush_unit_if.sv
// Branch-resolution bus between the EX stage and the flush controller.
// The master drives EX-stage branch information; the slave returns redirect, flush and statistics.
interface branch_flush_unit_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_zero;
  logic [XLEN-1:0]  ex_target;
  logic             stall;
  logic             pc_src;
  logic [XLEN-1:0]  pc_target;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output ex_valid, ex_branch, ex_zero, ex_target, stall,
    input  pc_src, pc_target, flush_ifid, flush_idex, flush_exmem,
           branch_count, taken_count
  );

  modport slave (
    input  ex_valid, ex_branch, ex_zero, ex_target, stall,
    output pc_src, pc_target, flush_ifid, flush_idex, flush_exmem,
           branch_count, taken_count
  );
endinterface

// File: rtl/branch_flush_unit.sv
// Branch resolution and pipeline flush controller: registers the taken decision into the
// MEM boundary, redirects the PC for one cycle and flushes for FLUSH_CYCLES cycles.
module branch_flush_unit #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             reset,
  branch_flush_unit_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t           state;
  logic [FC_W-1:0]  fcnt;
  logic             pc_src_p1;
  logic             flush_p1;
  logic [XLEN-1:0]  pc_target_p1;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic             accept;
  logic             taken;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Wrong-path branches arriving outside IDLE are squashed by the state term.
  assign accept = (state == IDLE) && bus.ex_valid && bus.ex_branch && !bus.stall;
  assign taken  = accept && bus.ex_zero;

  // EX -> MEM boundary: decision, target and statistics registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fcnt         <= '0;
      pc_src_p1    <= 1'b0;
      flush_p1     <= 1'b0;
      pc_target_p1 <= '0;
      branch_cnt   <= '0;
      taken_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) branch_cnt <= sat_inc(branch_cnt);
          if (taken) begin
            taken_cnt    <= sat_inc(taken_cnt);
            pc_target_p1 <= bus.ex_target;
            pc_src_p1    <= 1'b1;
            flush_p1     <= 1'b1;
            state        <= REDIRECT;
          end
        end
        REDIRECT: begin
          pc_src_p1 <= 1'b0;
          if (FLUSH_CYCLES > 1) begin
            fcnt     <= FC_LOAD;
            flush_p1 <= 1'b1;
            state    <= FLUSH;
          end else begin
            flush_p1 <= 1'b0;
            state    <= IDLE;
          end
        end
        FLUSH: begin
          if (fcnt == '0) begin
            flush_p1 <= 1'b0;
            state    <= IDLE;
          end else begin
            fcnt <= fcnt - FC_W'(1);
          end
        end
        default: begin
          pc_src_p1 <= 1'b0;
          flush_p1  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.pc_src       = pc_src_p1;
  assign bus.pc_target    = pc_target_p1;
  assign bus.flush_ifid   = flush_p1;
  assign bus.flush_idex   = flush_p1;
  assign bus.flush_exmem  = flush_p1;
  assign bus.branch_count = branch_cnt;
  assign bus.taken_count  = taken_cnt;

endmodule

// File: tb/tb_branch_flush_unit.sv
// Directed bench for branch_flush_unit: three instances (FLUSH_CYCLES 1/3/4, CNT_W 16/16/4),
// expected outputs queued per driven cycle and checked after the following clock edge.
module tb_branch_flush_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_flush_unit_if #(.XLEN(64), .CNT_W(16)) ifa ();
  branch_flush_unit_if #(.XLEN(64), .CNT_W(16)) ifb ();
  branch_flush_unit_if #(.XLEN(64), .CNT_W(4))  ifc ();

  branch_flush_unit #(.XLEN(64), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  branch_flush_unit #(.XLEN(64), .FLUSH_CYCLES(3), .CNT_W(16)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  branch_flush_unit #(.XLEN(64), .FLUSH_CYCLES(4), .CNT_W(4))  dut_c (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct packed {
    logic        src;
    logic [2:0]  fl;
    logic [63:0] tgt;
    logic [15:0] bc;
    logic [15:0] tc;
  } exp_t;

  exp_t        expq[$];
  string       tagq[$];
  int          sel;
  int          nchk  = 0;
  int          npass = 0;
  int          nfail = 0;
  logic [63:0] e_tgt;
  logic [15:0] e_bc;
  logic [15:0] e_tc;

  task automatic drive(input logic v, input logic b, input logic z, input logic [63:0] t, input logic s);
    case (sel)
      0: begin ifa.ex_valid = v; ifa.ex_branch = b; ifa.ex_zero = z; ifa.ex_target = t; ifa.stall = s; end
      1: begin ifb.ex_valid = v; ifb.ex_branch = b; ifb.ex_zero = z; ifb.ex_target = t; ifb.stall = s; end
      default: begin ifc.ex_valid = v; ifc.ex_branch = b; ifc.ex_zero = z; ifc.ex_target = t; ifc.stall = s; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t        e;
    string       tag;
    logic        src;
    logic [2:0]  fl;
    logic [63:0] tgt;
    logic [15:0] bc;
    logic [15:0] tc;
    e   = expq.pop_front();
    tag = tagq.pop_front();
    case (sel)
      0: begin src = ifa.pc_src; fl = {ifa.flush_ifid, ifa.flush_idex, ifa.flush_exmem};
               tgt = ifa.pc_target; bc = ifa.branch_count; tc = ifa.taken_count; end
      1: begin src = ifb.pc_src; fl = {ifb.flush_ifid, ifb.flush_idex, ifb.flush_exmem};
               tgt = ifb.pc_target; bc = ifb.branch_count; tc = ifb.taken_count; end
      default: begin src = ifc.pc_src; fl = {ifc.flush_ifid, ifc.flush_idex, ifc.flush_exmem};
               tgt = ifc.pc_target; bc = 16'(ifc.branch_count); tc = 16'(ifc.taken_count); end
    endcase
    chk({tag, ".pc_src"},       64'(src), 64'(e.src));
    chk({tag, ".flush"},        64'(fl),  64'(e.fl));
    chk({tag, ".pc_target"},    tgt,      e.tgt);
    chk({tag, ".branch_count"}, 64'(bc),  64'(e.bc));
    chk({tag, ".taken_count"},  64'(tc),  64'(e.tc));
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then check them.
  task automatic step(input logic v, input logic b, input logic z, input logic [63:0] t,
                      input logic s, input logic r, input logic src, input logic fl, input string tag);
    exp_t e;
    drive(v, b, z, t, s);
    reset = r;
    e.src = src;
    e.fl  = {3{fl}};
    e.tgt = e_tgt;
    e.bc  = e_bc;
    e.tc  = e_tc;
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clr();
    e_tgt = '0;
    e_bc  = '0;
    e_tc  = '0;
  endtask

  function automatic logic [15:0] sat15(input logic [15:0] v);
    return (v < 16'd15) ? v + 16'd1 : 16'd15;
  endfunction

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;

    sel = 0;
    clr();
    step(0, 0, 0, 64'h0,    0, 1, 0, 0, "A.reset");
    step(0, 0, 0, 64'h0,    0, 0, 0, 0, "A.idle");
    e_bc = 1; e_tc = 1; e_tgt = 64'h1040;
    step(1, 1, 1, 64'h1040, 0, 0, 1, 1, "A.taken");
    step(0, 0, 0, 64'h0,    0, 0, 0, 0, "A.after_taken");
    e_bc = 2;
    step(1, 1, 0, 64'h2000, 0, 0, 0, 0, "A.not_taken");
    step(0, 1, 1, 64'h2100, 0, 0, 0, 0, "A.no_valid");
    step(1, 0, 1, 64'h2200, 0, 0, 0, 0, "A.no_branch");
    clr();
    step(1, 1, 1, 64'h2300, 0, 1, 0, 0, "A.reset_vs_taken");
    e_bc = 1; e_tc = 1; e_tgt = 64'h3000;
    step(1, 1, 1, 64'h3000, 0, 0, 1, 1, "A.taken2");
    step(1, 1, 1, 64'h4000, 0, 0, 0, 0, "A.squash");
    e_bc = 2; e_tc = 2; e_tgt = 64'h4000;
    step(1, 1, 1, 64'h4000, 0, 0, 1, 1, "A.earliest");
    step(0, 0, 0, 64'h0,    0, 0, 0, 0, "A.drain");
    step(1, 1, 1, 64'h5000, 1, 0, 0, 0, "A.stall1");
    step(1, 1, 1, 64'h5000, 1, 0, 0, 0, "A.stall2");
    e_bc = 3; e_tc = 3; e_tgt = 64'h5000;
    step(1, 1, 1, 64'h5000, 0, 0, 1, 1, "A.unstall");
    step(0, 0, 0, 64'h0,    0, 0, 0, 0, "A.unstall_after");

    sel = 1;
    clr();
    step(0, 0, 0, 64'h0,    0, 1, 0, 0, "B.reset");
    e_bc = 1; e_tc = 1; e_tgt = 64'h6000;
    step(1, 1, 1, 64'h6000, 0, 0, 1, 1, "B.taken");
    step(1, 1, 1, 64'h7000, 0, 0, 0, 1, "B.squash1");
    step(1, 1, 1, 64'h7100, 0, 0, 0, 1, "B.squash2");
    step(1, 1, 1, 64'h7200, 0, 0, 0, 0, "B.squash3");
    e_bc = 2; e_tc = 2; e_tgt = 64'h9000;
    step(1, 1, 1, 64'h9000, 0, 0, 1, 1, "B.next");
    step(0, 0, 0, 64'h0,    1, 0, 0, 1, "B.stall_flush1");
    step(0, 0, 0, 64'h0,    1, 0, 0, 1, "B.stall_flush2");
    step(0, 0, 0, 64'h0,    1, 0, 0, 0, "B.done");
    drive(0, 0, 0, 64'h0, 0);

    sel = 2;
    clr();
    step(0, 0, 0, 64'h0,    0, 1, 0, 0, "C.reset");
    e_bc = 1; e_tc = 1; e_tgt = 64'hA000;
    step(1, 1, 1, 64'hA000, 0, 0, 1, 1, "C.taken");
    step(0, 0, 0, 64'h0,    0, 0, 0, 1, "C.flush2");
    clr();
    step(0, 0, 0, 64'h0,    0, 1, 0, 0, "C.reset_mid_flush");
    step(0, 0, 0, 64'h0,    0, 0, 0, 0, "C.no_residual");
    for (int i = 0; i < 20; i++) begin
      e_bc  = sat15(e_bc);
      e_tc  = sat15(e_tc);
      e_tgt = 64'h1_0000 + 64'(i) * 64'h10;
      step(1, 1, 1, e_tgt, 0, 0, 1, 1, "C.sat_taken");
      step(0, 0, 0, 64'h0, 0, 0, 0, 1, "C.sat_fl1");
      step(0, 0, 0, 64'h0, 0, 0, 0, 1, "C.sat_fl2");
      step(0, 0, 0, 64'h0, 0, 0, 0, 1, "C.sat_fl3");
      step(0, 0, 0, 64'h0, 0, 0, 0, 0, "C.sat_idle");
    end
    step(1, 1, 0, 64'hB000, 0, 0, 0, 0, "C.sat_not_taken");
    step(0, 0, 0, 64'h0,    0, 0, 0, 0, "C.sat_hold");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
